// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID and EX stages: opcodes, ALU op classes
// and the packed control bundle carried through ID/EX.
package id_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Don't-care control entries (sw/beq reg_dst, mem_to_reg) are driven as 0.
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = CTRL_NOP;
    case (opcode)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_OP_FUNCT;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_op     = ALU_OP_ADD;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALU_OP_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_OP_SUB;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file, two combinational read ports, one write port, r0 hardwired.
// Define ID_WB_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module id_stage_regfile
  import id_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data
);

  logic [31:0] mem [32];
  logic        wr_valid;

  assign wr_valid = wr_en && (wr_addr != 5'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (wr_valid) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs_data = (rs_addr == 5'd0) ? 32'd0 : mem[rs_addr];
    rt_data = (rt_addr == 5'd0) ? 32'd0 : mem[rt_addr];
`ifdef ID_WB_BYPASS_EN
    if (wr_valid && (wr_addr == rs_addr)) rs_data = wr_data;
    if (wr_valid && (wr_addr == rt_addr)) rt_data = wr_data;
`endif
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: decode, register read, sign-extend, load-use
// stall and the ID/EX pipeline register. ID_WB_BYPASS_EN enables WB write-through.
module id_stage
  import id_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] IFID_pc_i,
  input  logic [31:0] IFID_ir_i,
  input  logic        MEM_ctrl_pc_src_i,
  input  logic        WB_reg_write_i,
  input  logic [4:0]  WB_write_reg_i,
  input  logic [31:0] WB_write_data_i,
  output logic        stall_o,
  output logic [31:0] IDEX_pc_o,
  output logic [31:0] IDEX_rs_data_o,
  output logic [31:0] IDEX_rt_data_o,
  output logic [31:0] IDEX_imm_o,
  output logic [4:0]  IDEX_rs_o,
  output logic [4:0]  IDEX_rt_o,
  output logic [4:0]  IDEX_rd_o,
  output logic        IDEX_reg_write_o,
  output logic        IDEX_mem_to_reg_o,
  output logic        IDEX_mem_read_o,
  output logic        IDEX_mem_write_o,
  output logic        IDEX_branch_o,
  output logic        IDEX_alu_src_o,
  output logic        IDEX_reg_dst_o,
  output logic [1:0]  IDEX_alu_op_o
);

  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_data, rt_data, imm;
  ctrl_t       ctrl_dec, ctrl_q;
  logic        hazard;

  assign rs  = IFID_ir_i[25:21];
  assign rt  = IFID_ir_i[20:16];
  assign rd  = IFID_ir_i[15:11];
  assign imm = {{16{IFID_ir_i[15]}}, IFID_ir_i[15:0]};
  assign ctrl_dec = decode_ctrl(IFID_ir_i[31:26]);

  id_stage_regfile u_regfile (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .rs_addr (rs),
    .rt_addr (rt),
    .wr_en   (WB_reg_write_i),
    .wr_addr (WB_write_reg_i),
    .wr_data (WB_write_data_i),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  // Load in EX whose destination feeds this instruction: hold one cycle.
  assign hazard  = ctrl_q.mem_read && (IDEX_rt_o != 5'd0) &&
                   ((IDEX_rt_o == rs) || (IDEX_rt_o == rt));
  assign stall_o = hazard && !MEM_ctrl_pc_src_i;

  // Flush and stall both inject an all-zero bubble, data fields included.
  always_ff @(posedge clk_i) begin
    if (rst_i || MEM_ctrl_pc_src_i || hazard) begin
      ctrl_q         <= CTRL_NOP;
      IDEX_pc_o      <= '0;
      IDEX_rs_data_o <= '0;
      IDEX_rt_data_o <= '0;
      IDEX_imm_o     <= '0;
      IDEX_rs_o      <= '0;
      IDEX_rt_o      <= '0;
      IDEX_rd_o      <= '0;
    end else begin
      ctrl_q         <= ctrl_dec;
      IDEX_pc_o      <= IFID_pc_i;
      IDEX_rs_data_o <= rs_data;
      IDEX_rt_data_o <= rt_data;
      IDEX_imm_o     <= imm;
      IDEX_rs_o      <= rs;
      IDEX_rt_o      <= rt;
      IDEX_rd_o      <= rd;
    end
  end

  assign IDEX_reg_dst_o    = ctrl_q.reg_dst;
  assign IDEX_alu_src_o    = ctrl_q.alu_src;
  assign IDEX_mem_to_reg_o = ctrl_q.mem_to_reg;
  assign IDEX_reg_write_o  = ctrl_q.reg_write;
  assign IDEX_mem_read_o   = ctrl_q.mem_read;
  assign IDEX_mem_write_o  = ctrl_q.mem_write;
  assign IDEX_branch_o     = ctrl_q.branch;
  assign IDEX_alu_op_o     = ctrl_q.alu_op;

endmodule
